pipeline_hazard_controller: RTL

- Sequences the 5-stage pipeline around the EX-stage ALU.
- Detects load-use hazards that forwarding cannot cover, and stalls IF/ID for a configurable number of cycles while injecting bubbles into ID/EX.
- Flushes wrong-path instructions on taken BEQ (resolved in EX) and J (resolved in ID), and selects the next-PC source.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/pipeline_hazard_controller_if.sv | 39 +++
 rtl/pipeline_hazard_controller.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipeline_hazard_controller_if                                    |
// | ID/EX hazard inputs and PC / pipeline-register control outputs.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface pipeline_hazard_controller_if #(
  parameter int COUNT_WIDTH = 16
);
  logic [3:0]             op_type_ID;
  logic [4:0]             read_register_1_ID;
  logic [4:0]             read_register_2_ID;
  logic [3:0]             op_type_EX;
  logic                   reg_write_enable_EX;
  logic [4:0]             reg_write_address_EX;
  logic [31:0]            alu_result_EX;
  logic                   pc_write_enable;
  logic                   if_id_write_enable;
  logic                   if_id_flush;
  logic                   id_ex_flush;
  logic [1:0]             pc_sel;
  logic [COUNT_WIDTH-1:0] stall_cycle_count;
  logic [COUNT_WIDTH-1:0] flush_count;

  modport master (
    output op_type_ID, read_register_1_ID, read_register_2_ID,
           op_type_EX, reg_write_enable_EX, reg_write_address_EX, alu_result_EX,
    input  pc_write_enable, if_id_write_enable, if_id_flush, id_ex_flush,
           pc_sel, stall_cycle_count, flush_count
  );

  modport slave (
    input  op_type_ID, read_register_1_ID, read_register_2_ID,
           op_type_EX, reg_write_enable_EX, reg_write_address_EX, alu_result_EX,
    output pc_write_enable, if_id_write_enable, if_id_flush, id_ex_flush,
           pc_sel, stall_cycle_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipeline_hazard_controller                                       |
// | Load-use stall, BEQ/J flush, next-PC select, perf counters.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pipeline_hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int COUNT_WIDTH       = 16
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  pipeline_hazard_controller_if.slave  bus
);

  localparam logic [3:0] c_op_add = 4'd1;
  localparam logic [3:0] c_op_sub = 4'd2;
  localparam logic [3:0] c_op_and = 4'd3;
  localparam logic [3:0] c_op_or  = 4'd4;
  localparam logic [3:0] c_op_slt = 4'd5;
  localparam logic [3:0] c_op_lw  = 4'd6;
  localparam logic [3:0] c_op_sw  = 4'd7;
  localparam logic [3:0] c_op_beq = 4'd8;
  localparam logic [3:0] c_op_j   = 4'd9;

  localparam logic [0:0] c_st_run   = 1'b0;
  localparam logic [0:0] c_st_stall = 1'b1;

  localparam logic [1:0] c_pc_plus4  = 2'b00;
  localparam logic [1:0] c_pc_branch = 2'b01;
  localparam logic [1:0] c_pc_jump   = 2'b10;

  localparam bit         c_multi_cycle  = (LOAD_STALL_CYCLES > 1);
  localparam logic [1:0] c_stall_reload = 2'(LOAD_STALL_CYCLES - 1);

  logic [0:0]             r_state;
  logic [1:0]             r_stall_left;
  logic [COUNT_WIDTH-1:0] r_stall_cnt;
  logic [COUNT_WIDTH-1:0] r_flush_cnt;

  logic [0:0] w_state_nxt;
  logic [1:0] w_left_nxt;
  logic       w_uses_rt;
  logic       w_id_active;
  logic       w_load_use;
  logic       w_branch_taken;
  logic       w_flush_event;
  logic       w_pc_we;
  logic       w_ifid_we;
  logic       w_ifid_flush;
  logic       w_idex_flush;
  logic [1:0] w_pc_sel;
  logic       w_unused;

  // Only bit0 of the ALU result carries the BEQ compare outcome.
  assign w_unused = ^bus.alu_result_EX[31:1];

  always_comb begin
    w_uses_rt = 1'b0;
    case (bus.op_type_ID)
      c_op_add, c_op_sub, c_op_and, c_op_or,
      c_op_slt, c_op_beq, c_op_sw: w_uses_rt = 1'b1;
      default:                     w_uses_rt = 1'b0;
    endcase
  end

  assign w_id_active    = (bus.op_type_ID != 4'd0) && (bus.op_type_ID != c_op_j);
  assign w_load_use     = w_id_active
                       && (bus.op_type_EX == c_op_lw)
                       && bus.reg_write_enable_EX
                       && (bus.reg_write_address_EX != 5'd0)
                       && ((bus.reg_write_address_EX == bus.read_register_1_ID)
                        || (w_uses_rt && (bus.reg_write_address_EX == bus.read_register_2_ID)));
  assign w_branch_taken = (bus.op_type_EX == c_op_beq) && bus.alu_result_EX[0];

  always_comb begin
    w_pc_we       = 1'b1;
    w_ifid_we     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_pc_sel      = c_pc_plus4;
    w_flush_event = 1'b0;
    if (rst) begin
      w_pc_we      = 1'b0;
      w_ifid_we    = 1'b0;
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (w_branch_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_pc_sel      = c_pc_branch;
      w_flush_event = 1'b1;
    end else if ((r_state == c_st_stall) || w_load_use) begin
      w_pc_we      = 1'b0;
      w_ifid_we    = 1'b0;
      w_idex_flush = 1'b1;
    end else if (bus.op_type_ID == c_op_j) begin
      w_ifid_flush  = 1'b1;
      w_pc_sel      = c_pc_jump;
      w_flush_event = 1'b1;
    end
  end

  // A taken branch kills any stall; the bubble-carrying LW already left EX.
  always_comb begin
    w_state_nxt = r_state;
    w_left_nxt  = r_stall_left;
    if (w_branch_taken) begin
      w_state_nxt = c_st_run;
      w_left_nxt  = 2'd0;
    end else if (r_state == c_st_stall) begin
      w_left_nxt = r_stall_left - 2'd1;
      if (r_stall_left == 2'd1) begin
        w_state_nxt = c_st_run;
      end
    end else if (w_load_use && c_multi_cycle) begin
      w_state_nxt = c_st_stall;
      w_left_nxt  = c_stall_reload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_st_run;
      r_stall_left <= 2'd0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_stall_left <= w_left_nxt;
      if (!w_pc_we && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_event && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign bus.pc_write_enable    = w_pc_we;
  assign bus.if_id_write_enable = w_ifid_we;
  assign bus.if_id_flush        = w_ifid_flush;
  assign bus.id_ex_flush        = w_idex_flush;
  assign bus.pc_sel             = w_pc_sel;
  assign bus.stall_cycle_count  = r_stall_cnt;
  assign bus.flush_count        = r_flush_cnt;

endmodule
`default_nettype wire
